// File: rtl/pam4_sym_gen.sv
// pam4_sym_gen
//   PAM-4 test-symbol source with x4 zero-stuffing upsampler. Each accepted
//   symbol enable takes two bits from a 15-bit Fibonacci LFSR (x^15+x^14+1)
//   and Gray-maps them to a signed level. The level is emitted on sample
//   phase 0, and zeros are emitted on phases 1-3. The output feeds the SRRC
//   pulse-shaping filter.
//
// Parameters
//   WIDTH  sample word width (signed, 1sWIDTH-1)
//   MAG    inner level magnitude; outer level is 3*MAG (must fit in WIDTH)
//   SEED   LFSR reset / lock-up reload value (non-zero)
//
// Ports
//   clk           system clock
//   reset         asynchronous active-low reset
//   sam_clk_en    sample-rate enable, one pulse every 4 clk
//   sym_clk_en    symbol-rate enable, one pulse every 16 clk, on a sam pulse
//   run           1 = draw symbols, 0 = freeze LFSR and emit zeros
//   sym_out       last drawn symbol bits
//   sym_valid     one-cycle pulse when sym_out updates
//   sample_out    signed upsampled sample, updated on sam_clk_en
//   sample_phase  phase (0-3) of the current sample_out
//   synced        set by the first symbol boundary after reset
//   align_err     sticky enable-alignment error
module pam4_sym_gen #(
  parameter int          WIDTH = 18,
  parameter int          MAG   = 21845,
  parameter logic [14:0] SEED  = 15'h0001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sam_clk_en,
  input  logic                    sym_clk_en,
  input  logic                    run,
  output logic [1:0]              sym_out,
  output logic                    sym_valid,
  output logic signed [WIDTH-1:0] sample_out,
  output logic [1:0]              sample_phase,
  output logic                    synced,
  output logic                    align_err
);

  localparam logic signed [WIDTH-1:0] LVL_IN  = WIDTH'(MAG);
  localparam logic signed [WIDTH-1:0] LVL_OUT = WIDTH'(3 * MAG);

  // Gray map: adjacent levels differ in a single bit.
  function automatic logic signed [WIDTH-1:0] gray_map(input logic [1:0] bits);
    case (bits)
      2'b00:   gray_map = -LVL_OUT;
      2'b01:   gray_map = -LVL_IN;
      2'b11:   gray_map = LVL_IN;
      default: gray_map = LVL_OUT;
    endcase
  endfunction

  logic [14:0] lfsr;
  logic [14:0] lfsr_adv;
  logic [1:0]  phase;
  logic [1:0]  phase_nxt;
  logic        boundary;
  logic        accept;
  logic        misalign;

  always_comb begin
    boundary  = sym_clk_en & sam_clk_en;
    accept    = boundary & run;
    // Two Fibonacci steps at once: the first feedback bit lands in [1],
    // and the second (computed from the already-shifted register) lands in [0].
    lfsr_adv  = {lfsr[12:0], lfsr[14] ^ lfsr[13], lfsr[13] ^ lfsr[12]};
    phase_nxt = boundary ? 2'd0 : phase + 2'd1;
    // A sym pulse off the sample grid, or a sample after phase 3 that lacks
    // the symbol pulse, means the enables have lost alignment.
    misalign  = (sym_clk_en & ~sam_clk_en) |
                (synced & sam_clk_en & ~sym_clk_en & (phase == 2'd3));
  end

  // Output register stage: all outputs update one clk after the enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr         <= SEED;
      phase        <= 2'd0;
      sym_out      <= 2'b00;
      sym_valid    <= 1'b0;
      sample_out   <= '0;
      sample_phase <= 2'd0;
      synced       <= 1'b0;
      align_err    <= 1'b0;
    end else begin
      sym_valid <= accept;
      if (lfsr == 15'd0) begin
        lfsr <= SEED;
      end else if (accept) begin
        lfsr <= lfsr_adv;
      end
      if (accept) begin
        sym_out <= lfsr[1:0];
      end
      if (sam_clk_en) begin
        phase        <= phase_nxt;
        sample_phase <= phase_nxt;
        sample_out   <= accept ? gray_map(lfsr[1:0]) : '0;
      end
      if (boundary) begin
        synced <= 1'b1;
      end
      if (misalign) begin
        align_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pam4_sym_gen.sv
module tb_pam4_sym_gen;

  localparam int          WIDTH = 18;
  localparam int          MAG   = 21845;
  localparam logic [14:0] SEED  = 15'h0001;
  localparam int          NLONG = 20000;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    sam_clk_en;
  logic                    sym_clk_en;
  logic                    run;
  logic [1:0]              sym_out;
  logic                    sym_valid;
  logic signed [WIDTH-1:0] sample_out;
  logic [1:0]              sample_phase;
  logic                    synced;
  logic                    align_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [14:0] m_lfsr;
  logic [1:0]  m_prev;

  always #5 clk = ~clk;

  pam4_sym_gen #(.WIDTH(WIDTH), .MAG(MAG), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .run(run), .sym_out(sym_out), .sym_valid(sym_valid), .sample_out(sample_out),
    .sample_phase(sample_phase), .synced(synced), .align_err(align_err)
  );

  typedef struct {
    logic       sym;
    logic       valid;
    int         sample;
    int         phase;
    logic [1:0] symb;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [14:0] step1(input logic [14:0] l);
    return {l[13:0], l[14] ^ l[13]};
  endfunction

  function automatic int level(input logic [1:0] b);
    case (b)
      2'b00:   return -3 * MAG;
      2'b01:   return -MAG;
      2'b11:   return MAG;
      default: return 3 * MAG;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic y);
    sam_clk_en = s;
    sym_clk_en = y;
    @(posedge clk);
    #1;
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1'b0, 1'b0);
    reset = 1'b1;
    m_lfsr = SEED;
    m_prev = 2'b00;
  endtask

  // One aligned 16-clk symbol period, checked against the model.
  task automatic sym_period(input logic r);
    logic [1:0] b;
    run = r;
    b = m_lfsr[1:0];
    cyc(1'b1, 1'b1);
    chk("sp_valid", int'(sym_valid), int'(r));
    chk("sp_sym_out", int'(r ? b : m_prev), int'(sym_out));
    chk("sp_sample", int'(sample_out), r ? level(b) : 0);
    chk("sp_phase0", int'(sample_phase), 0);
    if (r) begin
      m_prev = b;
      m_lfsr = step1(step1(m_lfsr));
    end
    for (int p = 1; p < 4; p++) begin
      repeat (3) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      chk("sp_zero", int'(sample_out), 0);
      chk("sp_phase", int'(sample_phase), p);
    end
    repeat (3) cyc(1'b0, 1'b0);
  endtask

  initial begin
    int errs;
    int hist[4];
    reset      = 1'b0;
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    run        = 1'b0;
    m_lfsr     = SEED;
    m_prev     = 2'b00;

    tbl[0]  = '{1'b1, 1'b1, -21845, 0, 2'b01};
    tbl[1]  = '{1'b0, 1'b0, 0,      1, 2'b01};
    tbl[2]  = '{1'b0, 1'b0, 0,      2, 2'b01};
    tbl[3]  = '{1'b0, 1'b0, 0,      3, 2'b01};
    tbl[4]  = '{1'b1, 1'b1, -65535, 0, 2'b00};
    tbl[5]  = '{1'b0, 1'b0, 0,      1, 2'b00};
    tbl[6]  = '{1'b0, 1'b0, 0,      2, 2'b00};
    tbl[7]  = '{1'b0, 1'b0, 0,      3, 2'b00};
    tbl[8]  = '{1'b1, 1'b1, -65535, 0, 2'b00};
    tbl[9]  = '{1'b0, 1'b0, 0,      1, 2'b00};
    tbl[10] = '{1'b0, 1'b0, 0,      2, 2'b00};
    tbl[11] = '{1'b0, 1'b0, 0,      3, 2'b00};
    tbl[12] = '{1'b1, 1'b1, -65535, 0, 2'b00};
    tbl[13] = '{1'b0, 1'b0, 0,      1, 2'b00};
    tbl[14] = '{1'b0, 1'b0, 0,      2, 2'b00};
    tbl[15] = '{1'b0, 1'b0, 0,      3, 2'b00};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sym_out", int'(sym_out), 0);
    chk("rst_valid", int'(sym_valid), 0);
    chk("rst_sample", int'(sample_out), 0);
    chk("rst_phase", int'(sample_phase), 0);
    chk("rst_synced", int'(synced), 0);
    chk("rst_align", int'(align_err), 0);
    reset = 1'b1;
    run   = 1'b1;

    // Table: one row per sample period, SEED=1, aligned enables.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, tbl[i].sym);
      chk("tv_valid", int'(sym_valid), int'(tbl[i].valid));
      chk("tv_sample", int'(sample_out), tbl[i].sample);
      chk("tv_phase", int'(sample_phase), tbl[i].phase);
      chk("tv_sym_out", int'(sym_out), int'(tbl[i].symb));
      chk("tv_synced", int'(synced), 1);
      repeat (3) cyc(1'b0, 1'b0);
      chk("tv_hold", int'(sample_out), tbl[i].sample);
      chk("tv_valid_low", int'(sym_valid), 0);
    end
    chk("tv_align", int'(align_err), 0);

    // Pause for three symbols; the LFSR must resume where it stopped.
    m_lfsr = 15'h0100;
    m_prev = 2'b00;
    sym_period(1'b1);
    repeat (3) sym_period(1'b0);
    repeat (3) sym_period(1'b1);
    chk("pause_align", int'(align_err), 0);

    // Asynchronous reset in the middle of phase 2.
    run = 1'b1;
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("pre_rst_phase", int'(sample_phase), 2);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_sym_out", int'(sym_out), 0);
    chk("arst_valid", int'(sym_valid), 0);
    chk("arst_sample", int'(sample_out), 0);
    chk("arst_phase", int'(sample_phase), 0);
    chk("arst_synced", int'(synced), 0);
    chk("arst_align", int'(align_err), 0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    m_lfsr = SEED;
    m_prev = 2'b00;
    sym_period(1'b1);
    chk("post_rst_synced", int'(synced), 1);

    // Dense run: every cycle is a symbol boundary.
    do_reset();
    run  = 1'b1;
    errs = 0;
    for (int k = 0; k < 4; k++) hist[k] = 0;
    for (int i = 0; i < NLONG; i++) begin
      cyc(1'b1, 1'b1);
      if (sym_valid !== 1'b1 || sym_out !== m_lfsr[1:0] ||
          int'(sample_out) != level(m_lfsr[1:0]))
        errs++;
      hist[sym_out]++;
      m_lfsr = step1(step1(m_lfsr));
    end
    chk("long_mismatches", errs, 0);
    for (int k = 0; k < 4; k++)
      chk("long_level_share", int'(hist[k] > NLONG / 5 && hist[k] < (NLONG * 3) / 10), 1);
    chk("long_align", int'(align_err), 0);

    // A sym pulse without a sam pulse is an alignment error and sticks.
    do_reset();
    cyc(1'b0, 1'b1);
    chk("err_sym_only", int'(align_err), 1);
    chk("err_sym_only_nosync", int'(synced), 0);
    sym_period(1'b1);
    chk("err_sticky", int'(align_err), 1);
    do_reset();
    chk("err_cleared", int'(align_err), 0);

    // A missing symbol boundary after phase 3 is flagged once synced.
    cyc(1'b1, 1'b1);
    for (int p = 1; p < 4; p++) begin
      repeat (3) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
    end
    chk("miss_pre", int'(align_err), 0);
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("miss_sym", int'(align_err), 1);

    // The same pattern before sync is not an error.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      cyc(1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0);
    end
    chk("unsynced_no_err", int'(align_err), 0);
    chk("unsynced_flag", int'(synced), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
